// File: rtl/regfile_write_arbiter_if.sv
// Writeback port bundle between the two requesters, the register file
// write port and the snooped read addresses.
interface regfile_write_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 2
);
  logic                         hold;
  logic                         req0;
  logic                         req1;
  logic [ADDR_WIDTH-1:0]        reg0;
  logic [ADDR_WIDTH-1:0]        reg1;
  logic [DATA_WIDTH-1:0]        data0;
  logic [DATA_WIDTH-1:0]        data1;
  logic                         ack0;
  logic                         ack1;
  logic                         rf_write;
  logic [ADDR_WIDTH-1:0]        rf_write_reg;
  logic [DATA_WIDTH-1:0]        rf_write_data;
  logic [ADDR_WIDTH-1:0]        rd_reg1;
  logic [ADDR_WIDTH-1:0]        rd_reg2;
  logic [(2**ADDR_WIDTH)-1:0]   pending;
  logic                         stall;

  // Requester / pipeline side
  modport master (
    output hold, req0, req1, reg0, reg1, data0, data1, rd_reg1, rd_reg2,
    input  ack0, ack1, rf_write, rf_write_reg, rf_write_data, pending, stall
  );

  // Arbiter side
  modport slave (
    input  hold, req0, req1, reg0, reg1, data0, data1, rd_reg1, rd_reg2,
    output ack0, ack1, rf_write, rf_write_reg, rf_write_data, pending, stall
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port between the ALU
// writeback path (requester 0) and the load/immediate path (requester 1).
// Outputs are registered; pending/stall flag reads of an uncommitted write.
module regfile_write_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 2
) (
  input logic                    clk,
  input logic                    reset,
  regfile_write_arbiter_if.slave bus
);

  localparam int unsigned NUM_REGS = 2**ADDR_WIDTH;

  typedef enum logic {
    REQ0 = 1'b0,
    REQ1 = 1'b1
  } req_id_t;

  logic                  r_write;
  logic [ADDR_WIDTH-1:0] r_write_reg;
  logic [DATA_WIDTH-1:0] r_write_data;
  logic                  r_ack0;
  logic                  r_ack1;
  req_id_t               r_last;

  logic                  w_elig0;
  logic                  w_elig1;
  logic                  w_grant;
  req_id_t               w_grant_id;
  logic [NUM_REGS-1:0]   w_pending;
  logic                  w_stall;

  // A request already acked this cycle is masked so a held req is not granted twice
  assign w_elig0 = bus.req0 & ~r_ack0;
  assign w_elig1 = bus.req1 & ~r_ack1;

  // Grant selection: single eligible wins, tie goes to the one not granted last
  always_comb begin
    w_grant    = 1'b0;
    w_grant_id = REQ0;
    if (!bus.hold) begin
      if (w_elig0 && w_elig1) begin
        w_grant    = 1'b1;
        w_grant_id = (r_last == REQ0) ? REQ1 : REQ0;
      end else if (w_elig0) begin
        w_grant    = 1'b1;
        w_grant_id = REQ0;
      end else if (w_elig1) begin
        w_grant    = 1'b1;
        w_grant_id = REQ1;
      end
    end
  end

  // Registered write port, ack pulses and round-robin pointer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_write      <= 1'b0;
      r_write_reg  <= '0;
      r_write_data <= '0;
      r_ack0       <= 1'b0;
      r_ack1       <= 1'b0;
      r_last       <= REQ1;
    end else if (w_grant) begin
      r_write <= 1'b1;
      r_last  <= w_grant_id;
      if (w_grant_id == REQ0) begin
        r_write_reg  <= bus.reg0;
        r_write_data <= bus.data0;
        r_ack0       <= 1'b1;
        r_ack1       <= 1'b0;
      end else begin
        r_write_reg  <= bus.reg1;
        r_write_data <= bus.data1;
        r_ack0       <= 1'b0;
        r_ack1       <= 1'b1;
      end
    end else begin
      r_write <= 1'b0;
      r_ack0  <= 1'b0;
      r_ack1  <= 1'b0;
    end
  end

  // One-hot in-flight register, qualified by the write strobe
  always_comb begin
    w_pending = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      w_pending[i] = r_write && (r_write_reg == ADDR_WIDTH'(i));
    end
  end

  // Read hazard: either snooped read address targets the in-flight register
  always_comb begin
    w_stall = 1'b0;
    if (r_write && ((bus.rd_reg1 == r_write_reg) || (bus.rd_reg2 == r_write_reg))) begin
      w_stall = 1'b1;
    end
  end

  assign bus.rf_write      = r_write;
  assign bus.rf_write_reg  = r_write_reg;
  assign bus.rf_write_data = r_write_data;
  assign bus.ack0          = r_ack0;
  assign bus.ack1          = r_ack1;
  assign bus.pending       = w_pending;
  assign bus.stall         = w_stall;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: per-cycle expectations are queued
// as stimulus is applied and popped after each rising edge.
module tb_regfile_write_arbiter;

  logic clk;
  logic reset;

  regfile_write_arbiter_if #(.DATA_WIDTH(8), .ADDR_WIDTH(2)) bus ();

  regfile_write_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural register file fed by the arbiter's write port
  logic [7:0] mem [4] = '{default: 8'h00};
  always @(posedge clk) begin
    if (bus.rf_write) mem[bus.rf_write_reg] <= bus.rf_write_data;
  end

  typedef struct packed {
    logic       wr;
    logic       a0;
    logic       a1;
    logic [1:0] rg;
    logic [7:0] dt;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_err    = 0;
  int   n_cyc    = 0;
  int   n_writes = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_cyc(input logic wr, input logic a0, input logic a1,
                            input logic [1:0] rg, input logic [7:0] dt);
    exp_t e;
    e.wr = wr; e.a0 = a0; e.a1 = a1; e.rg = rg; e.dt = dt;
    q.push_back(e);
  endtask

  // Advance one edge, then compare against the oldest queued expectation
  task automatic step_check();
    exp_t       e;
    logic [3:0] exp_pend;
    logic       exp_stall;
    @(posedge clk);
    #1;
    n_cyc++;
    n_checks++;
    assert (q.size() != 0) else begin
      n_err++;
      $error("FAIL sb_empty cyc%0d observed=0 expected=1", n_cyc);
    end
    if (q.size() != 0) begin
      e = q.pop_front();
      if (e.wr) n_writes++;
      exp_pend  = e.wr ? (4'b0001 << e.rg) : 4'b0000;
      exp_stall = e.wr && ((bus.rd_reg1 == e.rg) || (bus.rd_reg2 == e.rg));
      check($sformatf("rf_write cyc%0d", n_cyc), 32'(bus.rf_write), 32'(e.wr));
      check($sformatf("ack0 cyc%0d", n_cyc), 32'(bus.ack0), 32'(e.a0));
      check($sformatf("ack1 cyc%0d", n_cyc), 32'(bus.ack1), 32'(e.a1));
      check($sformatf("pending cyc%0d", n_cyc), 32'(bus.pending), 32'(exp_pend));
      check($sformatf("stall cyc%0d", n_cyc), 32'(bus.stall), 32'(exp_stall));
      if (e.wr) begin
        check($sformatf("wr_reg cyc%0d", n_cyc), 32'(bus.rf_write_reg), 32'(e.rg));
        check($sformatf("wr_data cyc%0d", n_cyc), 32'(bus.rf_write_data), 32'(e.dt));
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset       = 1'b0;
    bus.hold    = 1'b0;
    bus.req0    = 1'b1;
    bus.req1    = 1'b0;
    bus.reg0    = 2'd1;
    bus.reg1    = 2'd0;
    bus.data0   = 8'hAA;
    bus.data1   = 8'h00;
    bus.rd_reg1 = 2'd0;
    bus.rd_reg2 = 2'd0;

    // Reset held with a live request: everything stays cleared
    #2;
    check("rst_write", 32'(bus.rf_write), 32'd0);
    check("rst_ack0", 32'(bus.ack0), 32'd0);
    check("rst_pending", 32'(bus.pending), 32'd0);
    @(posedge clk); #1;
    check("rst_edge_write", 32'(bus.rf_write), 32'd0);
    check("rst_edge_ack0", 32'(bus.ack0), 32'd0);

    // Release: first edge grants requester 0
    reset = 1'b1;
    expect_cyc(1'b1, 1'b1, 1'b0, 2'd1, 8'hAA);
    step_check();

    // Mid-cycle reset abandons the in-flight write immediately
    #2;
    reset = 1'b0;
    #1;
    check("midrst_write", 32'(bus.rf_write), 32'd0);
    check("midrst_ack0", 32'(bus.ack0), 32'd0);
    check("midrst_pending", 32'(bus.pending), 32'd0);
    #1;
    reset    = 1'b1;
    bus.req0 = 1'b0;
    expect_cyc(1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
    step_check();
    check("abandoned_r1", 32'(mem[1]), 32'h00);

    // Single write to r2 with a read hazard on rd_reg1
    bus.req0    = 1'b1;
    bus.reg0    = 2'd2;
    bus.data0   = 8'h55;
    bus.rd_reg1 = 2'd2;
    bus.rd_reg2 = 2'd0;
    expect_cyc(1'b1, 1'b1, 1'b0, 2'd2, 8'h55);
    step_check();
    bus.req0    = 1'b0;
    bus.rd_reg1 = 2'd3;
    #1;
    check("stall_miss_r3", 32'(bus.stall), 32'd0);
    bus.rd_reg1 = 2'd2;
    #1;
    check("stall_hit_r2", 32'(bus.stall), 32'd1);
    expect_cyc(1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
    step_check();
    check("commit_r2", 32'(mem[2]), 32'h55);

    // Reset pulse restores the pointer so requester 0 wins the first tie
    #2;
    reset = 1'b0;
    #2;
    reset = 1'b1;

    // Both requesters held: strict alternation, continuous write strobe
    bus.req0    = 1'b1;
    bus.reg0    = 2'd1;
    bus.data0   = 8'h11;
    bus.req1    = 1'b1;
    bus.reg1    = 2'd3;
    bus.data1   = 8'hCC;
    bus.rd_reg1 = 2'd0;
    bus.rd_reg2 = 2'd3;
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) expect_cyc(1'b1, 1'b1, 1'b0, 2'd1, 8'h11);
      else            expect_cyc(1'b1, 1'b0, 1'b1, 2'd3, 8'hCC);
      step_check();
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    expect_cyc(1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
    step_check();
    check("commit_r1", 32'(mem[1]), 32'h11);
    check("commit_r3", 32'(mem[3]), 32'hCC);

    // Single requester held for 6 cycles: a write every other cycle
    n_writes    = 0;
    bus.req1    = 1'b1;
    bus.reg1    = 2'd0;
    bus.data1   = 8'h3C;
    bus.rd_reg2 = 2'd1;
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) expect_cyc(1'b1, 1'b0, 1'b1, 2'd0, 8'h3C);
      else            expect_cyc(1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
      step_check();
    end
    bus.req1 = 1'b0;
    check("held_write_count", 32'(n_writes), 32'd3);
    check("commit_r0", 32'(mem[0]), 32'h3C);

    // Hold blocks new grants; release grants the requester not granted last (0)
    bus.hold  = 1'b1;
    bus.req0  = 1'b1;
    bus.reg0  = 2'd2;
    bus.data0 = 8'h77;
    bus.req1  = 1'b1;
    bus.reg1  = 2'd1;
    bus.data1 = 8'h99;
    expect_cyc(1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
    step_check();
    expect_cyc(1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
    step_check();
    bus.hold = 1'b0;
    expect_cyc(1'b1, 1'b1, 1'b0, 2'd2, 8'h77);
    step_check();
    bus.req0 = 1'b0;
    expect_cyc(1'b1, 1'b0, 1'b1, 2'd1, 8'h99);
    step_check();
    bus.req1 = 1'b0;
    expect_cyc(1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
    step_check();
    check("commit_r2_hold", 32'(mem[2]), 32'h77);
    check("commit_r1_hold", 32'(mem[1]), 32'h99);
    check("sb_drained", 32'(q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
